// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register: fetch PC, variable-latency
// instruction-memory handshake, stall/flush handling and branch/jump redirects.
module if_stage #(
   parameter int unsigned      WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_fetch,
   input  logic             stall_decode,
   input  logic             flush_decode,
   input  logic             pcsrc_decode,
   input  logic             jump_decode,
   input  logic [WIDTH-1:0] pc_branch,
   input  logic [WIDTH-1:0] pc_jump,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic [WIDTH-1:0] imem_rdata,
   input  logic             imem_ready,
   output logic [WIDTH-1:0] instr_decode,
   output logic [WIDTH-1:0] pc_decode,
   output logic             valid_decode,
   output logic             fetch_busy
);

   typedef enum logic {
      ST_RUN,
      ST_DISCARD
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] instr_q, instr_d;
   logic [WIDTH-1:0] pcd_q, pcd_d;
   logic             valid_q, valid_d;
   logic             req_q;

   logic             redir;
   logic             rsp;
   logic             load_word;
   logic [WIDTH-1:0] redir_target;
   logic [WIDTH-1:0] pc_plus4;

   assign redir        = pcsrc_decode | jump_decode;
   assign redir_target = jump_decode ? pc_jump : pc_branch;
   // A response only counts while a request is outstanding (not in the post-reset cycle).
   assign rsp          = req_q & imem_ready;
   assign pc_plus4     = pc_q + WIDTH'(4);

   // Fetch PC / redirect FSM.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      target_d  = target_q;
      load_word = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (!stall_fetch) begin
               if (rsp) begin
                  if (redir) begin
                     pc_d = redir_target;
                  end else begin
                     pc_d      = pc_plus4;
                     load_word = 1'b1;
                  end
               end else if (redir) begin
                  target_d = redir_target;
                  state_d  = ST_DISCARD;
               end
            end
         end
         ST_DISCARD: begin
            // The in-flight word belongs to the wrong path; a newer redirect wins.
            if (redir) target_d = redir_target;
            if (rsp) begin
               pc_d    = redir ? redir_target : target_q;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // IF/ID register: stall beats flush, flush beats load.
   always_comb begin
      instr_d = instr_q;
      pcd_d   = pcd_q;
      valid_d = valid_q;
      if (!stall_decode) begin
         if (load_word && !flush_decode) begin
            instr_d = imem_rdata;
            pcd_d   = pc_plus4;
            valid_d = 1'b1;
         end else begin
            instr_d = '0;
            pcd_d   = '0;
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         target_q <= '0;
         req_q    <= 1'b0;
         instr_q  <= '0;
         pcd_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
         req_q    <= 1'b1;
         instr_q  <= instr_d;
         pcd_q    <= pcd_d;
         valid_q  <= valid_d;
      end
   end

   assign imem_req     = req_q;
   assign imem_addr    = pc_q;
   assign instr_decode = instr_q;
   assign pc_decode    = pcd_q;
   assign valid_decode = valid_q;
   assign fetch_busy   = (state_q == ST_DISCARD) | (req_q & ~imem_ready);

   // The memory relies on the address staying put while a request is pending.
   addr_stable_a : assert property (@(posedge clk) disable iff (rst)
      (imem_req && !imem_ready) |=> $stable(imem_addr));

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, hand-written corner
// sequences, then randomized traffic against a rule-level reference model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_fetch, stall_decode, flush_decode, pcsrc_decode, jump_decode;
   logic [31:0] pc_branch, pc_jump;
   logic        imem_req;
   logic [31:0] imem_addr, imem_rdata;
   logic        imem_ready;
   logic [31:0] instr_decode, pc_decode;
   logic        valid_decode, fetch_busy;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        ready;
      logic        stall_f;
      logic        stall_d;
      logic        flush;
      logic        pcsrc;
      logic        jump;
      logic [31:0] pc_branch;
      logic [31:0] pc_jump;
   } stim_t;

   typedef struct packed {
      stim_t       s;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pcd;
      logic        e_busy;
   } vec_t;

   if_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .stall_fetch  (stall_fetch),
      .stall_decode (stall_decode),
      .flush_decode (flush_decode),
      .pcsrc_decode (pcsrc_decode),
      .jump_decode  (jump_decode),
      .pc_branch    (pc_branch),
      .pc_jump      (pc_jump),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .imem_ready   (imem_ready),
      .instr_decode (instr_decode),
      .pc_decode    (pc_decode),
      .valid_decode (valid_decode),
      .fetch_busy   (fetch_busy)
   );

   always #5 clk = ~clk;

   // Instruction memory contents: a fixed scramble of the address, never zero in practice.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_req, m_disc, m_valid;
   logic [31:0] m_pc, m_tgt, m_instr, m_pcd;

   task automatic model_reset();
      m_req = 0; m_disc = 0; m_valid = 0;
      m_pc = 32'h0; m_tgt = 32'h0; m_instr = 32'h0; m_pcd = 32'h0;
   endtask

   task automatic model_step(input stim_t s);
      bit          got, redir, deliver;
      logic [31:0] tgt, fetched;
      got     = m_req && s.ready;
      redir   = s.pcsrc || s.jump;
      tgt     = s.jump ? s.pc_jump : s.pc_branch;
      deliver = 0;
      fetched = m_pc;
      if (m_disc) begin
         if (redir) m_tgt = tgt;
         if (got) begin
            m_pc   = m_tgt;
            m_disc = 0;
         end
      end else if (!s.stall_f) begin
         if (got && !redir) begin
            deliver = 1;
            m_pc    = m_pc + 32'd4;
         end else if (got) begin
            m_pc = tgt;
         end else if (redir) begin
            m_tgt  = tgt;
            m_disc = 1;
         end
      end
      if (!s.stall_d) begin
         if (deliver && !s.flush) begin
            m_valid = 1; m_instr = mem_word(fetched); m_pcd = fetched + 32'd4;
         end else begin
            m_valid = 0; m_instr = 32'h0; m_pcd = 32'h0;
         end
      end
      m_req = 1;
   endtask

   task automatic compare_model(input string tag, input stim_t s);
      check({tag, ".addr"},  imem_addr,    m_pc);
      check({tag, ".req"},   32'(imem_req), 32'(m_req));
      check({tag, ".valid"}, 32'(valid_decode), 32'(m_valid));
      check({tag, ".instr"}, instr_decode, m_instr);
      check({tag, ".pcd"},   pc_decode,    m_pcd);
      check({tag, ".busy"},  32'(fetch_busy), 32'(m_disc || (m_req && !s.ready)));
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic drive(input stim_t s);
      imem_ready   = s.ready;
      stall_fetch  = s.stall_f;
      stall_decode = s.stall_d;
      flush_decode = s.flush;
      pcsrc_decode = s.pcsrc;
      jump_decode  = s.jump;
      pc_branch    = s.pc_branch;
      pc_jump      = s.pc_jump;
   endtask

   function automatic stim_t st(input logic rdy, input logic sf, input logic sd, input logic fl,
                                input logic br, input logic jp,
                                input logic [31:0] pb, input logic [31:0] pj);
      stim_t s;
      s.ready = rdy; s.stall_f = sf; s.stall_d = sd; s.flush = fl;
      s.pcsrc = br; s.jump = jp; s.pc_branch = pb; s.pc_jump = pj;
      return s;
   endfunction

   function automatic vec_t row(input stim_t s, input logic [31:0] addr, input logic valid,
                                input logic [31:0] pcd, input logic busy);
      vec_t v;
      v.s = s; v.e_addr = addr; v.e_valid = valid; v.e_pcd = pcd; v.e_busy = busy;
      return v;
   endfunction

   // Apply one cycle of inputs, compare against the model mid-cycle, advance past the edge.
   task automatic run_cycle(input stim_t s, input string tag);
      drive(s);
      @(negedge clk);
      compare_model(tag, s);
      @(posedge clk);
      model_step(s);
      #1;
   endtask

   vec_t  tbl[20];
   stim_t idle;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle = st(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
      // expectations are the outputs seen during the cycle the inputs are applied
      tbl[0]  = row(st(1,0,0,0,0,0,0,0),                 32'h00, 0, 32'h00, 0);
      tbl[1]  = row(st(1,0,0,0,0,0,0,0),                 32'h00, 0, 32'h00, 0);
      tbl[2]  = row(st(1,0,0,0,0,0,0,0),                 32'h04, 1, 32'h04, 0);
      tbl[3]  = row(st(0,0,0,0,0,0,0,0),                 32'h08, 1, 32'h08, 1);
      tbl[4]  = row(st(0,0,0,0,0,0,0,0),                 32'h08, 0, 32'h00, 1);
      tbl[5]  = row(st(0,0,0,0,0,0,0,0),                 32'h08, 0, 32'h00, 1);
      tbl[6]  = row(st(1,0,0,0,0,0,0,0),                 32'h08, 0, 32'h00, 0);
      tbl[7]  = row(st(1,0,0,0,0,0,0,0),                 32'h0C, 1, 32'h0C, 0);
      tbl[8]  = row(st(1,0,0,1,1,0,32'h40,0),            32'h10, 1, 32'h10, 0);
      tbl[9]  = row(st(1,0,0,0,0,0,0,0),                 32'h40, 0, 32'h00, 0);
      tbl[10] = row(st(1,0,0,1,1,0,32'h20,0),            32'h44, 1, 32'h44, 0);
      tbl[11] = row(st(0,0,0,1,0,1,0,32'h80),            32'h20, 0, 32'h00, 1);
      tbl[12] = row(st(0,0,0,0,0,0,0,0),                 32'h20, 0, 32'h00, 1);
      tbl[13] = row(st(1,0,0,0,0,0,0,0),                 32'h20, 0, 32'h00, 1);
      tbl[14] = row(st(1,0,0,0,0,0,0,0),                 32'h80, 0, 32'h00, 0);
      tbl[15] = row(st(1,0,0,0,0,0,0,0),                 32'h84, 1, 32'h84, 0);
      tbl[16] = row(st(1,1,1,1,1,0,32'h200,0),           32'h88, 1, 32'h88, 0);
      tbl[17] = row(st(1,1,1,1,1,0,32'h200,0),           32'h88, 1, 32'h88, 0);
      tbl[18] = row(st(1,0,0,0,0,0,0,0),                 32'h88, 1, 32'h88, 0);
      tbl[19] = row(st(1,0,0,0,0,0,0,0),                 32'h8C, 1, 32'h8C, 0);

      rst = 1'b1;
      drive(st(0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset.addr",  imem_addr, 32'h0);
      check("reset.req",   32'(imem_req), 32'h0);
      check("reset.valid", 32'(valid_decode), 32'h0);
      check("reset.instr", instr_decode, 32'h0);
      check("reset.pcd",   pc_decode, 32'h0);
      check("reset.busy",  32'(fetch_busy), 32'h0);
      rst = 1'b0;

      // directed table: sequential fetch, wait states, branch, jump during wait, stalls
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].s);
         @(negedge clk);
         check($sformatf("tbl%0d.addr", i),  imem_addr, tbl[i].e_addr);
         check($sformatf("tbl%0d.valid", i), 32'(valid_decode), 32'(tbl[i].e_valid));
         check($sformatf("tbl%0d.pcd", i),   pc_decode, tbl[i].e_pcd);
         check($sformatf("tbl%0d.instr", i), instr_decode,
               tbl[i].e_valid ? mem_word(tbl[i].e_pcd - 32'd4) : 32'h0);
         check($sformatf("tbl%0d.busy", i),  32'(fetch_busy), 32'(tbl[i].e_busy));
         @(posedge clk);
         model_step(tbl[i].s);
         #1;
      end

      // PC+4 wraps modulo 2^32
      run_cycle(st(1, 0, 0, 1, 1, 0, 32'hFFFF_FFFC, 32'h0), "wrap0");
      run_cycle(idle, "wrap1");
      check("wrap.addr",  imem_addr, 32'h0);
      check("wrap.pcd",   pc_decode, 32'h0);
      check("wrap.valid", 32'(valid_decode), 32'h1);
      check("wrap.instr", instr_decode, mem_word(32'hFFFF_FFFC));

      // reset arriving while a fetch at 0x30 is waiting
      run_cycle(st(1, 0, 0, 1, 1, 0, 32'h30, 32'h0), "mid0");
      run_cycle(st(0, 0, 0, 0, 0, 0, 32'h0, 32'h0), "mid1");
      #2;
      check("mid.addr", imem_addr, 32'h30);
      check("mid.busy", 32'(fetch_busy), 32'h1);
      rst = 1'b1;
      #1;
      model_reset();
      check("midrst.addr",  imem_addr, 32'h0);
      check("midrst.req",   32'(imem_req), 32'h0);
      check("midrst.valid", 32'(valid_decode), 32'h0);
      check("midrst.instr", instr_decode, 32'h0);
      check("midrst.pcd",   pc_decode, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_cycle(idle, "post0");
      run_cycle(idle, "post1");
      check("post.pcd",   pc_decode, 32'h4);
      check("post.instr", instr_decode, mem_word(32'h0));

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         stim_t s;
         s.ready     = ($urandom_range(0, 9) < 7);
         s.stall_f   = ($urandom_range(0, 9) == 0);
         s.stall_d   = s.stall_f ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
         s.pcsrc     = ($urandom_range(0, 11) == 0);
         s.jump      = ($urandom_range(0, 11) == 0);
         s.flush     = s.pcsrc | s.jump;
         s.pc_branch = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         s.pc_jump   = $urandom & 32'hFFFF_FFFC;
         run_cycle(s, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
